// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, split into two word accesses when it crosses a word.
// Store done 2-3 cycles after accept, load 3-4; req_ready (and !stall) only while idle, no queuing.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [2:0]            Funct3,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [1:0] {IDLE, A0, A1, RW} state_t;

  state_t                state;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     word0_q;
  logic [2:0]            funct3_q;
  logic                  is_read_q;

  logic [1:0]            offset;
  logic [2:0]            nbytes;
  logic [7:0]            lane_mask;
  logic [2*DATA_W-1:0]   lane_bits;
  logic [2*DATA_W-1:0]   wd_pair;
  logic                  crossing;
  logic [DM_ADDRESS-1:0] w0, w1;
  logic [2*DATA_W-1:0]   ld_pair;
  logic [DATA_W-1:0]     ld_word;
  logic [DATA_W-1:0]     ld_ext;

  assign offset = addr_q[1:0];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Lanes 0-3 belong to w0, lanes 4-7 spill into w1.
  assign lane_mask = 8'(((8'd1 << nbytes) - 8'd1) << offset);
  assign crossing  = |lane_mask[7:4];
  assign wd_pair   = {{DATA_W{1'b0}}, wdata_q} << {offset, 3'b000};

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < 8; i++) lane_bits[8*i +: 8] = {8{lane_mask[i]}};
  end

  assign w0 = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign w1 = w0 + DM_ADDRESS'(4);

  // In RW, mem_rd is the last word: word1 when crossing, otherwise the only word.
  assign ld_pair = crossing ? {mem_rd, word0_q} : {{DATA_W{1'b0}}, mem_rd};
  assign ld_word = DATA_W'(ld_pair >> {offset, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign stall     = !req_ready;

  always_comb begin
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_wr   = 4'b0000;
    mem_wd   = '0;
    case (state)
      A0: begin
        mem_addr = w0;
        if (is_read_q) mem_re = 1'b1;
        else begin
          mem_wr = lane_mask[3:0];
          mem_wd = wd_pair[DATA_W-1:0] & lane_bits[DATA_W-1:0];
        end
      end
      A1: begin
        mem_addr = w1;
        if (is_read_q) mem_re = 1'b1;
        else begin
          mem_wr = lane_mask[7:4];
          mem_wd = wd_pair[2*DATA_W-1:DATA_W] & lane_bits[2*DATA_W-1:DATA_W];
        end
      end
      default: ;
    endcase
    // No memory access may slip out while the block is being reset.
    if (reset) begin
      mem_re = 1'b0;
      mem_wr = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word0_q   <= '0;
      funct3_q  <= '0;
      is_read_q <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && (MemRead || MemWrite)) begin
            addr_q    <= addr;
            wdata_q   <= wdata;
            funct3_q  <= Funct3;
            is_read_q <= MemRead;
            state     <= A0;
          end
        end
        A0: begin
          if (crossing) state <= A1;
          else if (is_read_q) state <= RW;
          else begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
          end
        end
        A1: begin
          if (is_read_q) begin
            word0_q <= mem_rd;
            state   <= RW;
          end else begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
          end
        end
        RW: begin
          rdata     <= ld_ext;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model, response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, MemRead, MemWrite;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  Funct3;
  logic        stall, rsp_valid;
  logic [31:0] rdata;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic [3:0]  mem_wr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .Funct3(Funct3), .stall(stall), .rsp_valid(rsp_valid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Physical memory seen by the DUT.
  logic [7:0] dmem [0:511] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_re) mem_rd <= {dmem[int'(mem_addr)+3], dmem[int'(mem_addr)+2],
                           dmem[int'(mem_addr)+1], dmem[int'(mem_addr)]};
    for (int i = 0; i < 4; i++)
      if (mem_wr[i]) dmem[int'(mem_addr)+i] <= mem_wd[8*i +: 8];
  end

  // Reference model: flat byte memory, addresses wrap at 512.
  logic [7:0]  refm [0:511] = '{default: 8'h00};
  logic [31:0] last_load = '0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f3);
    logic [31:0] v = '0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refm[(int'(a) + i) % 512];
    case (f3)
      3'b000: v = {{24{v[7]}}, v[7:0]};
      3'b001: v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [8:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) refm[(int'(a) + i) % 512] = d[8*i +: 8];
  endtask

  // Per-cycle observations after an accept edge, index 1..4 = T+1..T+4.
  logic [8:0]  o_addr [1:4];
  logic        o_re   [1:4];
  logic [3:0]  o_wr   [1:4];
  logic [31:0] o_wd   [1:4];
  logic        o_rsp  [1:4];
  logic [31:0] o_rdat [1:4];
  logic        o_stl  [1:4];

  task automatic issue(input bit rd, input bit wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f3, input bit rec);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = d; Funct3 = f3;
    if (rd) begin
      last_load = model_load(a, f3);
      exp_q.push_back(last_load);
    end else begin
      model_store(a, d, size_of(f3));
      exp_q.push_back(last_load);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (rec) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        o_addr[k] = mem_addr; o_re[k] = mem_re; o_wr[k] = mem_wr; o_wd[k] = mem_wd;
        o_rsp[k] = rsp_valid; o_rdat[k] = rdata; o_stl[k] = stall;
      end
    end
  endtask

  // Monitor: every completion pops one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      chk("stall_vs_ready", {31'b0, stall}, {31'b0, !req_ready});
      if ((mem_re || mem_wr != 4'b0) && mem_addr[1:0] != 2'b00)
        chk("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h expected no response", rdata);
      end else chk("rsp_rdata", rdata, exp_q.pop_front());
    end
  end

  initial begin
    int guard;
    int mism;
    logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] sf3 [3] = '{3'b000, 3'b001, 3'b010};
    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    addr = '0; wdata = '0; Funct3 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rst_mem_wr", {28'b0, mem_wr}, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

    // Aligned LW.
    issue(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0);
    issue(1, 0, 9'h010, 32'h0, 3'b010, 1);
    chk("lw_re_t1", {31'b0, o_re[1]}, 32'h1);
    chk("lw_addr_t1", {23'b0, o_addr[1]}, 32'h010);
    chk("lw_stall_t1", {31'b0, o_stl[1]}, 32'h1);
    chk("lw_stall_t2", {31'b0, o_stl[2]}, 32'h1);
    chk("lw_rsp_t2", {31'b0, o_rsp[2]}, 32'h0);
    chk("lw_rsp_t3", {31'b0, o_rsp[3]}, 32'h1);
    chk("lw_rdata_t3", o_rdat[3], 32'hDEADBEEF);

    // Crossing LH / LHU.
    issue(0, 1, 9'h010, 32'hAABBCCDD, 3'b010, 0);
    issue(0, 1, 9'h014, 32'h112233F0, 3'b010, 0);
    issue(1, 0, 9'h013, 32'h0, 3'b001, 1);
    chk("lh_addr_t1", {23'b0, o_addr[1]}, 32'h010);
    chk("lh_re_t2", {31'b0, o_re[2]}, 32'h1);
    chk("lh_addr_t2", {23'b0, o_addr[2]}, 32'h014);
    chk("lh_rsp_t3", {31'b0, o_rsp[3]}, 32'h0);
    chk("lh_rsp_t4", {31'b0, o_rsp[4]}, 32'h1);
    chk("lh_rdata_t4", o_rdat[4], 32'hFFFFF0AA);
    issue(1, 0, 9'h013, 32'h0, 3'b101, 1);
    chk("lhu_rdata_t4", o_rdat[4], 32'h0000F0AA);

    // Crossing SW with address wrap.
    issue(0, 1, 9'h1FE, 32'h12345678, 3'b010, 1);
    chk("sw_addr_t1", {23'b0, o_addr[1]}, 32'h1FC);
    chk("sw_wr_t1", {28'b0, o_wr[1]}, 32'hC);
    chk("sw_wd_t1", o_wd[1], 32'h56780000);
    chk("sw_addr_t2", {23'b0, o_addr[2]}, 32'h000);
    chk("sw_wr_t2", {28'b0, o_wr[2]}, 32'h3);
    chk("sw_wd_t2", o_wd[2], 32'h00001234);
    chk("sw_rsp_t2", {31'b0, o_rsp[2]}, 32'h0);
    chk("sw_rsp_t3", {31'b0, o_rsp[3]}, 32'h1);

    // SB then sign/zero loads; read wins when both flags set.
    issue(0, 1, 9'h005, 32'h000000A5, 3'b000, 1);
    chk("sb_addr_t1", {23'b0, o_addr[1]}, 32'h004);
    chk("sb_wr_t1", {28'b0, o_wr[1]}, 32'h2);
    chk("sb_wd_t1", o_wd[1], 32'h0000A500);
    chk("sb_rsp_t2", {31'b0, o_rsp[2]}, 32'h1);
    issue(1, 0, 9'h005, 32'h0, 3'b000, 1);
    chk("lb_rdata", o_rdat[3], 32'hFFFFFFA5);
    issue(1, 0, 9'h005, 32'h0, 3'b100, 1);
    chk("lbu_rdata", o_rdat[3], 32'h000000A5);
    issue(1, 1, 9'h010, 32'hFFFFFFFF, 3'b010, 1);
    chk("both_re_t1", {31'b0, o_re[1]}, 32'h1);
    chk("both_wr_t1", {28'b0, o_wr[1]}, 32'h0);
    chk("both_rsp_t3", {31'b0, o_rsp[3]}, 32'h1);

    // A request with no operation is ignored.
    @(negedge clk);
    req_valid = 1'b1; addr = 9'h020; Funct3 = 3'b010;
    mism = 0;
    repeat (3) begin
      @(negedge clk);
      if (stall || mem_re || mem_wr != 4'b0) mism++;
    end
    req_valid = 1'b0;
    chk("noop_ignored", mism, 0);

    // Reset during the second half of a crossing store.
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; addr = 9'h1FE; wdata = 32'hCAFEF00D; Funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0; MemWrite = 1'b0;
    model_store(9'h1FE, 32'hCAFEF00D, 2);
    @(negedge clk);
    chk("rstmid_wr_t1", {28'b0, mem_wr}, 32'hC);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstmid_wr_t2", {28'b0, mem_wr}, 32'h0);
    chk("rstmid_re_t2", {31'b0, mem_re}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    last_load = '0;
    @(negedge clk);
    chk("rstmid_ready", {31'b0, req_ready}, 32'h1);
    chk("rstmid_rsp", {31'b0, rsp_valid}, 32'h0);
    chk("rstmid_rdata", rdata, 32'h0);
    issue(1, 0, 9'h1FC, 32'h0, 3'b010, 0);
    issue(1, 0, 9'h000, 32'h0, 3'b010, 0);

    // Randomised back-to-back traffic.
    for (int i = 0; i < 300; i++) begin
      logic [8:0] ra = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1)
        issue(0, 1, ra, $urandom, sf3[$urandom_range(0, 2)], 0);
      else
        issue(1, 0, ra, $urandom, lf3[$urandom_range(0, 4)], 0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 512; i++) if (dmem[i] !== refm[i]) mism++;
    chk("mem_image_mismatches", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
